// File: rtl/checkpoint_seq_monitor_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : checkpoint_seq_monitor_if
// Brief   : Control, status-bus and result signals of the checkpoint monitor.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
interface checkpoint_seq_monitor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             clear;
  logic [WIDTH-1:0] checkbits;
  logic [3:0]       step_idx;
  logic             step_pulse;
  logic             busy;
  logic             pass;
  logic             fail;
  logic             fail_timeout;
  logic [WIDTH-1:0] fail_code;

  modport master (
    output start, clear, checkbits,
    input  step_idx, step_pulse, busy, pass, fail, fail_timeout, fail_code
  );

  modport slave (
    input  start, clear, checkbits,
    output step_idx, step_pulse, busy, pass, fail, fail_timeout, fail_code
  );
endinterface
`default_nettype wire

// File: rtl/checkpoint_seq_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : checkpoint_seq_monitor
// Brief   : Matches an ordered list of checkpoint codes on a filtered status bus.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module checkpoint_seq_monitor #(
  parameter int                         WIDTH          = 16,
  parameter int                         NUM_STEPS      = 5,
  parameter logic [NUM_STEPS*WIDTH-1:0] STEP_CODES     = {16'hAB51, 16'hAB43, 16'hAB42,
                                                          16'hAB41, 16'hAB40},
  parameter logic [WIDTH-1:0]           PREFIX_MASK    = 16'hFF00,
  parameter int                         STABLE_CYCLES  = 4,
  parameter int                         TIMEOUT_CYCLES = 400000,
  parameter bit                         STRICT         = 1'b1
) (
  input  wire logic                   clock,
  input  wire logic                   resetb,
  checkpoint_seq_monitor_if.slave     mon
);

  localparam int c_scw = $clog2(STABLE_CYCLES + 1);
  localparam int c_tw  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_scw-1:0] c_stable   = c_scw'(STABLE_CYCLES);
  localparam logic [c_tw-1:0]  c_tmo_last = c_tw'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [c_tw-1:0]  c_tmo_sat  = (TIMEOUT_CYCLES > 0) ? c_tw'(TIMEOUT_CYCLES)
                                                                 : {c_tw{1'b1}};

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_armed = 2'd1;
  localparam logic [1:0] c_pass  = 2'd2;
  localparam logic [1:0] c_fail  = 2'd3;

  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [c_scw-1:0] r_stab_cnt;
  logic             r_consumed;
  logic [1:0]       r_state, w_next_state;
  logic [3:0]       r_step_idx;
  logic [c_tw-1:0]  r_tmo_cnt;
  logic             r_step_pulse;
  logic             r_fail_timeout;
  logic [WIDTH-1:0] r_fail_code;

  logic             w_sync_changed, w_arm, w_stable, w_last, w_has_prev;
  logic             w_match, w_order_fail, w_tmo_hit, w_armed;
  logic             w_busy, w_pass, w_fail;
  logic [WIDTH-1:0] w_exp_code, w_prev_code;

  assign w_armed        = (r_state == c_armed);
  assign w_sync_changed = (r_sync1 != r_sync2);
  assign w_arm          = mon.start && !mon.clear && !w_armed;
  // A stable value is acted on once; it must change before it can match again.
  assign w_stable       = (r_stab_cnt == c_stable) && !r_consumed;
  assign w_last         = (int'(r_step_idx) == NUM_STEPS - 1);

  always_comb begin
    w_exp_code  = '0;
    w_prev_code = '0;
    w_has_prev  = 1'b0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (int'(r_step_idx) == k) begin
        w_exp_code = STEP_CODES[k*WIDTH +: WIDTH];
      end
      if (int'(r_step_idx) == k + 1) begin
        w_prev_code = STEP_CODES[k*WIDTH +: WIDTH];
        w_has_prev  = 1'b1;
      end
    end
  end

  assign w_match      = w_armed && w_stable && (r_sync2 == w_exp_code);
  assign w_order_fail = (STRICT != 1'b0) && w_armed && w_stable && !w_match
                        && ((r_sync2 & PREFIX_MASK) == (STEP_CODES[WIDTH-1:0] & PREFIX_MASK))
                        && !(w_has_prev && (r_sync2 == w_prev_code));
  assign w_tmo_hit    = (TIMEOUT_CYCLES > 0) && w_armed && (r_tmo_cnt == c_tmo_last);

  // Arming restarts the filter so a code already on the bus still needs a full hold.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stab_cnt <= '0;
      r_consumed <= 1'b0;
    end else begin
      r_sync1 <= mon.checkbits;
      r_sync2 <= r_sync1;
      if (w_sync_changed || w_arm) begin
        r_stab_cnt <= c_scw'(1);
      end else if (r_stab_cnt != c_stable) begin
        r_stab_cnt <= r_stab_cnt + c_scw'(1);
      end
      if (w_sync_changed || w_arm) begin
        r_consumed <= 1'b0;
      end else if (w_match) begin
        r_consumed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (mon.clear) begin
      w_next_state = c_idle;
    end else begin
      case (r_state)
        c_armed: begin
          if (w_match && w_last) begin
            w_next_state = c_pass;
          end else if (!w_match && (w_order_fail || w_tmo_hit)) begin
            w_next_state = c_fail;
          end
        end
        default: begin
          if (mon.start) begin
            w_next_state = c_armed;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state == c_armed);
    w_pass = (r_state == c_pass);
    w_fail = (r_state == c_fail);
  end

  // Match outranks both failure causes; order violation outranks timeout.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_step_idx     <= '0;
      r_tmo_cnt      <= '0;
      r_step_pulse   <= 1'b0;
      r_fail_timeout <= 1'b0;
      r_fail_code    <= '0;
    end else begin
      r_step_pulse <= 1'b0;
      if (mon.clear || w_arm) begin
        r_step_idx     <= '0;
        r_tmo_cnt      <= '0;
        r_fail_timeout <= 1'b0;
        r_fail_code    <= '0;
      end else if (w_armed) begin
        if (w_match) begin
          r_step_pulse <= 1'b1;
          r_tmo_cnt    <= '0;
          if (!w_last) begin
            r_step_idx <= r_step_idx + 4'd1;
          end
        end else if (w_order_fail) begin
          r_fail_code <= r_sync2;
        end else if (w_tmo_hit) begin
          r_fail_timeout <= 1'b1;
          r_fail_code    <= '0;
        end else if (r_tmo_cnt != c_tmo_sat) begin
          r_tmo_cnt <= r_tmo_cnt + c_tw'(1);
        end
      end
    end
  end

  assign mon.step_idx     = r_step_idx;
  assign mon.step_pulse   = r_step_pulse;
  assign mon.busy         = w_busy;
  assign mon.pass         = w_pass;
  assign mon.fail         = w_fail;
  assign mon.fail_timeout = r_fail_timeout;
  assign mon.fail_code    = r_fail_code;

endmodule
`default_nettype wire

// File: tb/tb_checkpoint_seq_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_checkpoint_seq_monitor
// Brief   : Directed and random stimulus against a time-stamp reference model.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module tb_checkpoint_seq_monitor;

  localparam int STABLE = 4;
  localparam int P_IDLE = 0, P_ARMED = 1, P_PASS = 2, P_FAIL = 3;
  localparam logic [4:0][15:0] CODES0 = {16'hAB51, 16'hAB43, 16'hAB42, 16'hAB41, 16'hAB40};
  localparam logic [4:0][15:0] CODES1 = {48'h0, 16'hAB41, 16'hAB40};

  typedef struct {
    int          phase;
    int          step;
    bit          pulse;
    bit          ftmo;
    logic [15:0] fcode;
    int          arm_n;   // edge at which the monitor was last armed
    int          acc_n;   // edge of the last accepted step
    int          base_n;  // edge the current timeout window started
    int          run_n;   // edge the synchronised value last changed
    logic [15:0] d1;
    logic [15:0] d2;
  } mdl_t;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] bus = 16'h0;
  int          n = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          pulse_cnt0 = 0;
  mdl_t        m0, m1;

  always #5 clock = ~clock;

  checkpoint_seq_monitor_if #(.WIDTH(16)) if0 ();
  checkpoint_seq_monitor_if #(.WIDTH(16)) if1 ();

  assign if0.start = start;
  assign if0.clear = clear;
  assign if0.checkbits = bus;
  assign if1.start = start;
  assign if1.clear = clear;
  assign if1.checkbits = bus;

  checkpoint_seq_monitor #(
    .WIDTH(16), .NUM_STEPS(5), .STEP_CODES(CODES0), .PREFIX_MASK(16'hFF00),
    .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(100), .STRICT(1'b1)
  ) dut (
    .clock(clock), .resetb(resetb), .mon(if0.slave)
  );

  checkpoint_seq_monitor #(
    .WIDTH(16), .NUM_STEPS(2), .STEP_CODES(32'hAB41_AB40), .PREFIX_MASK(16'hFF00),
    .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(0), .STRICT(1'b0)
  ) dut_ns (
    .clock(clock), .resetb(resetb), .mon(if1.slave)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  function automatic mdl_t mdl_reset(input int at);
    mdl_t r;
    r.phase = P_IDLE; r.step = 0; r.pulse = 1'b0; r.ftmo = 1'b0; r.fcode = 16'h0;
    r.arm_n = -1000; r.acc_n = -1000; r.base_n = 0; r.run_n = at;
    r.d1 = 16'h0; r.d2 = 16'h0;
    return r;
  endfunction

  // Rules: a bus value reaches the matcher two edges after it is sampled and counts once
  // it has been held STABLE edges since it appeared or since arming, whichever is later.
  function automatic mdl_t mdl_step(input mdl_t m, input int at, input bit st, input bit cl,
                                    input logic [15:0] b, input bit strict, input int ns,
                                    input int tmo, input logic [4:0][15:0] codes);
    mdl_t        r;
    logic [15:0] s;
    int          since;
    bit          stable;
    r = m;
    s = m.d2;
    since = (m.run_n > m.arm_n) ? m.run_n : m.arm_n;
    stable = (at - since >= STABLE) && !(m.acc_n > since);
    r.pulse = 1'b0;
    if (cl) begin
      r.phase = P_IDLE; r.step = 0; r.ftmo = 1'b0; r.fcode = 16'h0;
    end else if (m.phase == P_ARMED) begin
      if (stable && s == codes[m.step]) begin
        r.pulse = 1'b1; r.acc_n = at; r.base_n = at;
        if (m.step == ns - 1) r.phase = P_PASS;
        else r.step = m.step + 1;
      end else if (strict && stable && (s & 16'hFF00) == (codes[0] & 16'hFF00)
                   && !(m.step > 0 && s == codes[m.step-1])) begin
        r.phase = P_FAIL; r.fcode = s;
      end else if (tmo > 0 && at - m.base_n >= tmo) begin
        r.phase = P_FAIL; r.ftmo = 1'b1; r.fcode = 16'h0;
      end
    end else if (st) begin
      r.phase = P_ARMED; r.step = 0; r.arm_n = at; r.base_n = at;
      r.ftmo = 1'b0; r.fcode = 16'h0;
    end
    if (m.d1 != m.d2) r.run_n = at;
    r.d2 = m.d1;
    r.d1 = b;
    return r;
  endfunction

  function automatic logic [31:0] pack_exp(input mdl_t m);
    return {7'd0, 4'(m.step), m.pulse, m.phase == P_ARMED, m.phase == P_PASS,
            m.phase == P_FAIL, m.ftmo, m.fcode};
  endfunction

  function automatic logic [31:0] dut0();
    return {7'd0, if0.step_idx, if0.step_pulse, if0.busy, if0.pass, if0.fail,
            if0.fail_timeout, if0.fail_code};
  endfunction

  function automatic logic [31:0] dut1();
    return {7'd0, if1.step_idx, if1.step_pulse, if1.busy, if1.pass, if1.fail,
            if1.fail_timeout, if1.fail_code};
  endfunction

  task automatic model_edge();
    n++;
    if (!resetb) begin
      m0 = mdl_reset(n);
      m1 = mdl_reset(n);
    end else begin
      m0 = mdl_step(m0, n, start, clear, bus, 1'b1, 5, 100, CODES0);
      m1 = mdl_step(m1, n, start, clear, bus, 1'b0, 2, 0, CODES1);
    end
  endtask

  task automatic step_cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_value("outs0", dut0(), pack_exp(m0));
    check_value("outs1", dut1(), pack_exp(m1));
    if (if0.step_pulse) pulse_cnt0++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step_cycle();
  endtask

  task automatic hold(input logic [15:0] v, input int cycles);
    bus = v;
    run(cycles);
  endtask

  task automatic pulse_start();
    start = 1'b1; step_cycle(); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; step_cycle(); clear = 1'b0;
  endtask

  task automatic arm_fresh();
    do_clear(); bus = 16'h0; run(3); pulse_start();
  endtask

  task automatic wait_pulse(output int at, input int limit);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step_cycle();
      if (if0.step_pulse) begin at = n; break; end
    end
  endtask

  task automatic wait_fail(output int at, input int limit);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step_cycle();
      if (if0.fail) begin at = n; break; end
    end
  endtask

  initial begin
    int          t0, t1, pc, r, sel, len;
    logic [15:0] v;
    m0 = mdl_reset(0);
    m1 = mdl_reset(0);

    run(3);
    check_value("reset_state0", dut0(), 32'h0);
    check_value("reset_state1", dut1(), 32'h0);
    resetb = 1'b1;
    run(3);

    // Happy path through all five codes
    pulse_start();
    pc = pulse_cnt0;
    for (int k = 0; k < 5; k++) hold(CODES0[k], 10);
    check_value("happy_pulses", 32'(pulse_cnt0 - pc), 32'd5);
    check_value("happy_pass", 32'(if0.pass), 32'd1);
    check_value("happy_idx", 32'(if0.step_idx), 32'd4);

    // Glitch rejection and filter latency
    arm_fresh();
    pc = pulse_cnt0;
    hold(16'hAB40, 2);
    hold(16'h0000, 8);
    check_value("glitch_nopulse", 32'(pulse_cnt0 - pc), 32'd0);
    t0 = n;
    bus = 16'hAB40;
    wait_pulse(t1, 20);
    check_value("filter_latency", 32'(t1 - t0), 32'd6);

    // Strict order violation after a stray non-prefix code
    arm_fresh();
    hold(16'h1234, 8);
    hold(16'hAB40, 8);
    hold(16'hAB42, 8);
    check_value("order_fail", 32'(if0.fail), 32'd1);
    check_value("order_cause", 32'(if0.fail_timeout), 32'd0);
    check_value("order_code", 32'(if0.fail_code), 32'hAB42);
    check_value("order_idx", 32'(if0.step_idx), 32'd1);
    check_value("order_busy", 32'(if0.busy), 32'd0);

    // Timeout fires exactly 100 cycles after the last acceptance
    arm_fresh();
    bus = 16'hAB40;
    wait_pulse(t0, 20);
    bus = 16'h0000;
    wait_fail(t1, 150);
    check_value("tmo_delay", 32'(t1 - t0), 32'd100);
    check_value("tmo_cause", 32'(if0.fail_timeout), 32'd1);
    check_value("tmo_code", 32'(if0.fail_code), 32'h0);

    // A match landing on the timeout cycle wins
    arm_fresh();
    bus = 16'hAB40;
    wait_pulse(t0, 20);
    run(94);
    bus = 16'hAB41;
    run(6);
    check_value("tmo_edge_pulse", 32'(if0.step_pulse), 32'd1);
    check_value("tmo_edge_fail", 32'(if0.fail), 32'd0);

    // Clear while armed, then re-arm after a pass
    arm_fresh();
    hold(16'hAB40, 8);
    do_clear();
    check_value("clear_out", dut0(), 32'h0);
    bus = 16'h0; run(3); pulse_start();
    for (int k = 0; k < 5; k++) hold(CODES0[k], 8);
    hold(16'h0000, 8);
    pulse_start();
    check_value("rearm_busy", 32'(if0.busy), 32'd1);
    check_value("rearm_pass", 32'(if0.pass), 32'd0);

    // Asynchronous reset in the middle of a step
    hold(16'hAB40, 8);
    bus = 16'hAB41;
    run(2);
    @(posedge clock);
    model_edge();
    #2 resetb = 1'b0;
    #1;
    check_value("async_rst0", dut0(), 32'h0);
    check_value("async_rst1", dut1(), 32'h0);
    m0 = mdl_reset(n);
    m1 = mdl_reset(n);
    @(negedge clock);
    step_cycle();
    resetb = 1'b1;
    pc = pulse_cnt0;
    run(10);
    check_value("rst_nopulse", 32'(pulse_cnt0 - pc), 32'd0);

    // Non-strict two-step instance ignores the unexpected code
    arm_fresh();
    hold(16'hAB43, 8);
    hold(16'hAB40, 8);
    hold(16'hAB41, 8);
    check_value("ns_pass", 32'(if1.pass), 32'd1);
    check_value("ns_fail", 32'(if1.fail), 32'd0);

    // Random traffic
    for (int it = 0; it < 260; it++) begin
      r = $urandom_range(0, 99);
      if (r < 7) begin
        pulse_start();
      end else if (r < 10) begin
        do_clear();
      end else begin
        sel = $urandom_range(0, 4);
        case (sel)
          0:       v = CODES0[m0.step];
          1:       v = CODES0[$urandom_range(0, 4)];
          2:       v = {8'hAB, 8'($urandom)};
          3:       v = 16'($urandom);
          default: v = 16'h0000;
        endcase
        len = $urandom_range(1, 12);
        hold(v, len);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
